// File: rtl/irq_pending_arb_if.sv
// Request handshake between irq_pending_arb (master) and its consumer (slave).
interface irq_pending_arb_if #(
  parameter int unsigned IDX_W = 3
);
  logic             req_valid;
  logic [IDX_W-1:0] req_idx;
  logic             req_ready;

  modport master (output req_valid, output req_idx, input req_ready);
  modport slave  (input req_valid, input req_idx, output req_ready);
endinterface

// File: rtl/irq_pending_arb.sv
// Sticky edge-captured interrupt pending bits, masked vector to the encoder, and an MSB-first
// valid/ready offer of one pending line at a time. Optional overflow flags: IRQ_OVERFLOW_EN.
module irq_pending_arb #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          irq_in,
  input  logic [N-1:0]          mask_in,
  output logic [N-1:0]          pend_vec,
  irq_pending_arb_if.master     req,
  output logic [N-1:0]          ovf,
  input  logic                  ovf_clr
);

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     irq_prev_q;
  logic [N-1:0]     edge_v, clr_v;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] top_idx;
  logic             handshake;

  assign edge_v    = irq_in & ~irq_prev_q;
  assign pend_vec  = pending_q & mask_in;
  assign handshake = valid_q & req.req_ready;
  assign clr_v     = handshake ? (N'(1) << idx_q) : '0;

  // Set wins over a same-cycle clear of the same bit.
  assign pending_d = (pending_q & ~clr_v) | edge_v;

  // Ascending scan so the highest set index is the last one written.
  always_comb begin
    top_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pend_vec[i]) top_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (|pend_vec) begin
          idx_d   = top_idx;
          valid_d = 1'b1;
          state_d = StOffer;
        end
      end
      StOffer: begin
        if (req.req_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      irq_prev_q <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_in;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
    end
  end

  assign req.req_valid = valid_q;
  assign req.req_idx   = idx_q;

`ifdef IRQ_OVERFLOW_EN
  logic [N-1:0] ovf_q, ovf_d;

  // A new overflow beats a simultaneous clear.
  always_comb begin
    ovf_d = ovf_clr ? '0 : ovf_q;
    ovf_d = ovf_d | (edge_v & pending_q & ~clr_v);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = '0;
`endif

endmodule

// File: tb/tb_irq_pending_arb.sv
// Randomized and directed bench for irq_pending_arb against a cycle-level behavioural model.
module tb_irq_pending_arb;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in, mask_in, pend_vec, ovf;
  logic       ovf_clr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit [7:0] m_pend, m_prev, m_ovf;
  bit       m_offer;
  int       m_idx;

  irq_pending_arb_if #(.IDX_W(3)) req_if ();

  irq_pending_arb #(.N(8), .IDX_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_in   (irq_in),
    .mask_in  (mask_in),
    .pend_vec (pend_vec),
    .req      (req_if),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_ovf = '0; m_offer = 0; m_idx = 0;
  endtask

  function automatic int highest(input bit [7:0] v);
    for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  // One clock of the model, using the inputs applied for this cycle.
  task automatic model_clock();
    bit       accept;
    bit [7:0] edges, nxt;
    accept = m_offer && req_if.req_ready;
    edges  = irq_in & ~m_prev;
    nxt    = m_pend;
    if (accept) nxt[m_idx] = 1'b0;
    nxt = nxt | edges;
`ifdef IRQ_OVERFLOW_EN
    if (ovf_clr) m_ovf = '0;
    for (int i = 0; i < N; i++)
      if (edges[i] && m_pend[i] && !(accept && m_idx == i)) m_ovf[i] = 1'b1;
`endif
    if (m_offer) begin
      if (accept) m_offer = 0;
    end else if ((m_pend & mask_in) != 0) begin
      m_idx   = highest(m_pend & mask_in);
      m_offer = 1;
    end
    m_pend = nxt;
    m_prev = irq_in;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pend_vec"}, pend_vec, m_pend & mask_in);
    check({tag, ".valid"}, req_if.req_valid, m_offer);
    check({tag, ".idx"}, req_if.req_idx, m_idx);
    check({tag, ".ovf"}, ovf, m_ovf);
  endtask

  task automatic step(input logic [7:0] irq_v, input logic [7:0] mask_v, input logic rdy_v,
                      input logic clr_v = 1'b0);
    @(negedge clk);
    irq_in = irq_v; mask_in = mask_v; req_if.req_ready = rdy_v; ovf_clr = clr_v;
    @(posedge clk);
    model_clock();
    #1 compare_all("cyc");
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; mask_in = 8'hFF; req_if.req_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    #12 compare_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Single pulse on line 3
    step(8'h08, 8'hFF, 1'b0);
    check("t1.pend", pend_vec, 8'h08);
    step(8'h00, 8'hFF, 1'b0);
    check("t1.valid", req_if.req_valid, 1'b1);
    check("t1.idx", req_if.req_idx, 3);
    step(8'h00, 8'hFF, 1'b1);
    check("t1.pend_clr", pend_vec, 8'h00);
    check("t1.valid_lo", req_if.req_valid, 1'b0);

    // Two lines together: 6 then 1, with an idle cycle between
    step(8'h42, 8'hFF, 1'b1);
    check("t2.pend", pend_vec, 8'h42);
    step(8'h00, 8'hFF, 1'b1);
    check("t2.idx6", req_if.req_idx, 6);
    step(8'h00, 8'hFF, 1'b1);
    check("t2.pend02", pend_vec, 8'h02);
    check("t2.gap", req_if.req_valid, 1'b0);
    step(8'h00, 8'hFF, 1'b1);
    check("t2.idx1", req_if.req_idx, 1);
    step(8'h00, 8'hFF, 1'b1);
    check("t2.pend00", pend_vec, 8'h00);

    // Offer stays stable against a higher-priority edge
    step(8'h04, 8'hFF, 1'b0);
    step(8'h00, 8'hFF, 1'b0);
    step(8'h80, 8'hFF, 1'b0);
    check("t3.hold", req_if.req_idx, 2);
    step(8'h00, 8'hFF, 1'b1);
    step(8'h00, 8'hFF, 1'b0);
    check("t3.next", req_if.req_idx, 7);
    step(8'h00, 8'hFF, 1'b1);

    // Masked pending becomes eligible when unmasked
    step(8'h10, 8'hEF, 1'b0);
    check("t4.masked", pend_vec, 8'h00);
    step(8'h00, 8'hEF, 1'b0);
    check("t4.noval", req_if.req_valid, 1'b0);
    step(8'h00, 8'hFF, 1'b0);
    check("t4.unmask", pend_vec, 8'h10);
    check("t4.idx", req_if.req_idx, 4);
    step(8'h00, 8'hFF, 1'b1);

    // Overflow on a second edge while pending
    step(8'h20, 8'hFF, 1'b0);
    step(8'h00, 8'hFF, 1'b0);
    step(8'h20, 8'hFF, 1'b0);
`ifdef IRQ_OVERFLOW_EN
    check("t5.ovf", ovf, 8'h20);
`else
    check("t5.ovf", ovf, 8'h00);
`endif
    step(8'h00, 8'hFF, 1'b0, 1'b1);
    check("t5.clr", ovf, 8'h00);
    step(8'h00, 8'hFF, 1'b1);

    // Asynchronous reset mid-offer
    step(8'h40, 8'hFF, 1'b0);
    step(8'h00, 8'hFF, 1'b0);
    check("t6.offer", req_if.req_idx, 6);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("t6.rst_valid", req_if.req_valid, 1'b0);
    check("t6.rst_pend", pend_vec, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    step(8'h00, 8'hFF, 1'b1);
    step(8'h00, 8'hFF, 1'b1);
    check("t6.quiet", req_if.req_valid, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] irq_r, mask_r;
      irq_r  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      mask_r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      step(irq_r, mask_r, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/irq_pending_arb.md
Name: irq_pending_arb

Overview:
Upstream capture-and-dispatch stage for the 8-input priority encoder path.
- Turns raw per-line interrupt requests into sticky pending bits.
- Applies a mask and drives the masked pending vector to the encoder input.
- Independently selects the highest-index masked pending line (MSB wins, same rule as the encoder) and offers it on a valid/ready handshake.
- Clears the pending bit on acceptance.

Parameters:
N, 8, number of request lines.
IDX_W, 3, index width; must equal clog2(N).

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
irq_in  input  N  request levels, already synchronous to clk.
mask_in  input  N  1 = line enabled; may change any cycle.
pend_vec  output  N  registered pending AND mask_in; feeds encoder "in".
req_valid  output  1  offered request valid.
req_idx  output  IDX_W  index of the offered line.
req_ready  input  1  consumer accepts when req_valid and req_ready are both high at a posedge.
ovf  output  N  sticky overflow flags (see Optional Feature).
ovf_clr  input  1  clears all ovf bits.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pending = 0, irq_prev = 0, state = IDLE.
  - req_valid = 0, req_idx = 0, ovf = 0, pend_vec = 0.
- Reset mid-offer drops the offer immediately; no handshake completes.
- Edge capture, at every posedge:
  - irq_prev <= irq_in.
  - Edge on bit i when irq_in[i] = 1 and irq_prev[i] = 0; pending[i] <= 1.
  - Because irq_prev resets to 0, a line held high through reset release counts as an edge on the first clock.
- pend_vec = pending & mask_in. The AND with mask_in is combinational on the registered pending vector.
- Masked pending bits stay pending and become eligible when unmasked.
- State machine, two states:
  - IDLE: if pend_vec is nonzero, latch req_idx = highest set index of pend_vec, set req_valid = 1, go to OFFER. Otherwise stay in IDLE with req_valid = 0.
  - OFFER: req_valid and req_idx are held stable until handshake. They are not changed by new higher-priority edges, mask changes, or the offered line becoming masked.
  - OFFER on handshake: pending[req_idx] <= 0, req_valid <= 0, go to IDLE.
- Throughput is one grant per 2 cycles; req_valid is low for at least one cycle between grants.
- Latency: edge sampled at posedge k sets pending at k; req_valid is high after posedge k+1 if the state was IDLE.
- Simultaneous clear (handshake) and new edge on the same bit in one cycle: set wins, and the bit remains pending.
- req_ready is ignored while req_valid = 0.
- All outputs are registered except pend_vec.

Optional Feature:
IRQ_OVERFLOW_EN
- Defined:
  - ovf[i] <= 1 when an edge on bit i arrives while pending[i] is already 1 and is not being cleared that cycle.
  - An edge arriving on the same cycle as the handshake clearing that bit is the set-wins case and does not flag.
  - ovf_clr = 1 clears all bits at the posedge. A simultaneous new overflow on the same cycle wins over the clear.
- Undefined: ovf is tied to 0 and ovf_clr is ignored. Ports remain so the bench is shared.

Test Plan:
- Release reset with irq_in = 0 and mask_in = 8'hFF, pulse irq_in[3] for one cycle -> pend_vec = 8'h08 one cycle after the edge; req_valid = 1, req_idx = 3 the following cycle; req_ready = 1 -> pend_vec = 8'h00, req_valid = 0 next cycle.
- Pulse irq_in[1] and irq_in[6] in the same cycle, hold req_ready = 1 -> grants idx 6 then idx 1, with one idle cycle between; pend_vec goes 8'h42 -> 8'h02 -> 8'h00.
- Offer idx 2 with req_ready = 0, then pulse irq_in[7] -> req_idx stays 2 until ready; after acceptance, next offer is idx 7.
- mask_in = 8'hEF, pulse irq_in[4] -> pend_vec = 0, no req_valid; set mask_in = 8'hFF -> pend_vec = 8'h10, offer idx 4 next cycle.
- With IRQ_OVERFLOW_EN: pulse irq_in[5] twice with req_ready = 0 -> ovf = 8'h20; ovf_clr = 1 -> ovf = 0. Without the macro, ovf stays 0.
- Assert rst_n = 0 mid-OFFER (idx 6 pending) -> req_valid = 0 and pend_vec = 0 immediately; after release, no offer unless a new edge occurs.
